// File: rtl/pingpong_pkg.sv
// Shared types and constants for the ping-pong SRAM pass sequencer.
package pingpong_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 128;
    localparam int PAIR_W = 7;    // rd/wr pair pointers, 0..127
    localparam int PASS_W = 4;    // pass counter, 0..15
    localparam int RD_LAT = 1;    // SRAM read latency in cycles

    // Parking addresses: the write bank is written every cycle, so idle
    // writes land here instead of on live data.
    localparam logic [ADDR_W-1:0] DUMMY_ADDR1 = 8'hFE;
    localparam logic [ADDR_W-1:0] DUMMY_ADDR2 = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_SWAP  = 2'd3
    } state_t;

    // Word address of one half of a pair: even word for port 1, odd for port 2.
    function automatic logic [ADDR_W-1:0] pair_addr(input logic [PAIR_W-1:0] ptr,
                                                    input logic              odd);
        return {ptr, odd};
    endfunction

endpackage

// File: rtl/pingpong_bank_sel.sv
// Pass counter and bank-select toggle. The bank flips once per SWAP and
// is left untouched by a new job, so it only returns to 0 on reset.
module pingpong_bank_sel
    import pingpong_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,       // accepted job start
    input  logic              swap,        // FSM is in SWAP this cycle
    input  logic [PASS_W-1:0] num_passes,
    output logic              bank,
    output logic              last_pass    // current SWAP completes the job
);

    logic [PASS_W-1:0] pass_cnt;
    logic [PASS_W-1:0] npass_q;

    // Latch pass count on start; count passes and flip bank on each SWAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_cnt <= '0;
            npass_q  <= '0;
            bank     <= 1'b0;
        end else if (clear) begin
            pass_cnt <= '0;
            npass_q  <= num_passes;
        end else if (swap) begin
            pass_cnt <= pass_cnt + PASS_W'(1);
            bank     <= ~bank;
        end
    end

    // Compare against the post-increment count so done can be decided in SWAP.
    assign last_pass = (pass_cnt + PASS_W'(1)) == npass_q;

endmodule

// File: rtl/pingpong_seq.sv
// Ping-pong SRAM pass sequencer: streams address pairs out of the read
// bank, writes returning result pairs into the other bank, swaps banks
// between passes and repeats for the requested number of passes.
module pingpong_seq #(
    parameter logic [pingpong_pkg::ADDR_W-1:0] DUMMY_ADDR1 = pingpong_pkg::DUMMY_ADDR1,
    parameter logic [pingpong_pkg::ADDR_W-1:0] DUMMY_ADDR2 = pingpong_pkg::DUMMY_ADDR2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [pingpong_pkg::PAIR_W-1:0]   num_pairs,
    input  logic [pingpong_pkg::PASS_W-1:0]   num_passes,
    input  logic                              rd_ready,
    input  logic                              res_valid,
    input  logic [pingpong_pkg::DATA_W-1:0]   res_data1,
    input  logic [pingpong_pkg::DATA_W-1:0]   res_data2,
    output logic [pingpong_pkg::ADDR_W-1:0]   raddress1,
    output logic [pingpong_pkg::ADDR_W-1:0]   raddress2,
    output logic [pingpong_pkg::ADDR_W-1:0]   waddress1,
    output logic [pingpong_pkg::ADDR_W-1:0]   waddress2,
    output logic [pingpong_pkg::DATA_W-1:0]   wdata1,
    output logic [pingpong_pkg::DATA_W-1:0]   wdata2,
    output logic                              sram_read_register,
    output logic                              rd_valid,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);

    import pingpong_pkg::*;

    state_t            state, state_nxt;
    logic [PAIR_W-1:0] np_q;
    logic [PAIR_W-1:0] rd_ptr, wr_ptr;
    logic [RD_LAT:1]   vld_pipe;
    logic              start_ok, job_ok;
    logic              issue, last_issue;
    logic              accept, wr_last;
    logic              last_pass;

    // Start qualification, read issue and result acceptance.
    always_comb begin
        start_ok   = (state == ST_IDLE) && start;
        job_ok     = start_ok && (num_pairs != '0) && (num_passes != '0);
        issue      = (state == ST_READ) && rd_ready;
        last_issue = issue && (rd_ptr == (np_q - PAIR_W'(1)));
        accept     = res_valid && ((state == ST_READ) || (state == ST_DRAIN))
                     && (wr_ptr < np_q);
        // Writes are complete either already or with this cycle's result.
        wr_last    = (wr_ptr == np_q) || (accept && ((wr_ptr + PAIR_W'(1)) == np_q));
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (job_ok)     state_nxt = ST_READ;
            ST_READ:  if (last_issue) state_nxt = ST_DRAIN;
            ST_DRAIN: if (wr_last)    state_nxt = ST_SWAP;
            ST_SWAP:  state_nxt = last_pass ? ST_IDLE : ST_READ;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Job parameters and read/write pair pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            np_q   <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (job_ok) begin
            np_q   <= num_pairs;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (state == ST_SWAP) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (issue)  rd_ptr <= rd_ptr + PAIR_W'(1);
            if (accept) wr_ptr <= wr_ptr + PAIR_W'(1);
        end
    end

    // Read-valid delay line matching the SRAM read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= (vld_pipe << 1) | RD_LAT'(issue);
    end

    // Done pulse (zero-length job or final SWAP) and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            done <= (start_ok && !job_ok) || ((state == ST_SWAP) && last_pass);
            // A dropped result in the same cycle as a start still flags.
            if (res_valid && !accept) err <= 1'b1;
            else if (start_ok)        err <= 1'b0;
        end
    end

    pingpong_bank_sel u_bank_sel (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (job_ok),
        .swap       (state == ST_SWAP),
        .num_passes (num_passes),
        .bank       (sram_read_register),
        .last_pass  (last_pass)
    );

    // Memory-interface outputs; writes park unless a result is accepted.
    always_comb begin
        raddress1 = '0;
        raddress2 = '0;
        if (state == ST_READ) begin
            raddress1 = pair_addr(rd_ptr, 1'b0);
            raddress2 = pair_addr(rd_ptr, 1'b1);
        end
        waddress1 = DUMMY_ADDR1;
        waddress2 = DUMMY_ADDR2;
        wdata1    = '0;
        wdata2    = '0;
        if (accept) begin
            waddress1 = pair_addr(wr_ptr, 1'b0);
            waddress2 = pair_addr(wr_ptr, 1'b1);
            wdata1    = res_data1;
            wdata2    = res_data2;
        end
    end

    assign rd_valid = vld_pipe[RD_LAT];
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_pingpong_seq.sv
// Scoreboard bench for pingpong_seq: stimulus pushes expected reads,
// writes and done events; a negedge monitor pops and compares them.
module tb_pingpong_seq;

    typedef struct packed {
        logic [7:0]   a1;
        logic [7:0]   a2;
        logic [127:0] d1;
        logic [127:0] d2;
    } wr_t;

    logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, rd_ready = 1'b0;
    logic [6:0]   num_pairs = '0;
    logic [3:0]   num_passes = '0;
    logic         res_valid;
    logic [127:0] res_data1, res_data2;
    logic [7:0]   raddress1, raddress2, waddress1, waddress2;
    logic [127:0] wdata1, wdata2;
    logic         sram_read_register, rd_valid, busy, done, err;

    // Result sources: a reactive datapath model and manual injection.
    logic         dp_en = 1'b1, dp_valid = 1'b0, man_valid = 1'b0;
    logic [127:0] dp_d1 = '0, dp_d2 = '0, man_d1 = '0, man_d2 = '0;
    logic [6:0]   dp_k = '0;
    int           dp_np = 1, seq = 0;

    assign res_valid = dp_valid | man_valid;
    assign res_data1 = dp_valid ? dp_d1 : man_d1;
    assign res_data2 = dp_valid ? dp_d2 : man_d2;

    logic [15:0] rd_exp[$];
    wr_t         wr_exp[$];
    logic        done_exp[$];

    int   checks = 0, errors = 0;
    int   done_cnt = 0, tog_cnt = 0, t0;
    logic exp_bank = 1'b0;
    logic [7:0] prev_ra1 = '0, prev_ra2 = '0;
    logic prev_rdy = 1'b0, prev_bank = 1'b0;

    pingpong_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_pairs(num_pairs),
        .num_passes(num_passes), .rd_ready(rd_ready), .res_valid(res_valid),
        .res_data1(res_data1), .res_data2(res_data2),
        .raddress1(raddress1), .raddress2(raddress2),
        .waddress1(waddress1), .waddress2(waddress2),
        .wdata1(wdata1), .wdata2(wdata2),
        .sram_read_register(sram_read_register), .rd_valid(rd_valid),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s at %0t", nm, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents an event.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid) begin
                if (rd_exp.size() == 0) fail("rd_valid_unexpected");
                else begin
                    chk("rd_pair", {prev_ra1, prev_ra2}, rd_exp.pop_front());
                    chk("rd_issue_ready", prev_rdy, 1'b1);
                end
            end
            if (waddress1 != 8'hFE) begin
                if (wr_exp.size() == 0) fail("wr_unexpected");
                else begin
                    chk("wr_a1", waddress1, wr_exp[0].a1);
                    chk("wr_a2", waddress2, wr_exp[0].a2);
                    chk("wr_d1", wdata1, wr_exp[0].d1);
                    chk("wr_d2", wdata2, wr_exp[0].d2);
                    wr_exp.delete(0);
                end
            end else begin
                chk("park2", waddress2, 8'hFF);
            end
            if (done) begin
                if (done_exp.size() == 0) fail("done_unexpected");
                else chk("done_bank", sram_read_register, done_exp.pop_front());
                chk("done_busy", busy, 1'b0);
                done_cnt <= done_cnt + 1;
            end
        end
        if (sram_read_register !== prev_bank) tog_cnt <= tog_cnt + 1;
        prev_bank <= sram_read_register;
        prev_ra1  <= raddress1;
        prev_ra2  <= raddress2;
        prev_rdy  <= rd_ready;
    end

    // Datapath model: returns one result pair in each rd_valid cycle.
    initial begin
        forever begin
            tick();
            if (dp_en && rst_n && rd_valid) begin
                seq++;
                dp_d1    = {4{32'hA500_0000 + 32'(seq)}};
                dp_d2    = {4{32'h5A00_0000 ^ 32'(seq * 3)}};
                dp_valid = 1'b1;
                wr_exp.push_back('{{dp_k, 1'b0}, {dp_k, 1'b1}, dp_d1, dp_d2});
                dp_k = (int'(dp_k) + 1 == dp_np) ? 7'd0 : dp_k + 7'd1;
            end else begin
                dp_valid = 1'b0;
            end
        end
    end

    task automatic pulse_start(input int np, input int ps);
        num_pairs  = 7'(np);
        num_passes = 4'(ps);
        dp_np      = (np == 0) ? 1 : np;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    // Full job: queue every read pair and the done event, then start.
    task automatic run_job(input int np, input int ps);
        if (np != 0 && ps != 0) begin
            for (int p = 0; p < ps; p++)
                for (int i = 0; i < np; i++)
                    rd_exp.push_back({8'(2 * i), 8'(2 * i + 1)});
            if (ps % 2 == 1) exp_bank = ~exp_bank;
        end
        done_exp.push_back(exp_bank);
        pulse_start(np, ps);
    endtask

    task automatic wait_done(input int target);
        for (int i = 0; i < 400 && done_cnt < target; i++) tick();
        if (done_cnt < target) fail("done_timeout");
    endtask

    initial begin
        #2;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_bank", sram_read_register, 1'b0);
        chk("rst_rd_valid", rd_valid, 1'b0);
        chk("rst_raddr", {raddress1, raddress2}, 16'h0000);
        chk("rst_park", {waddress1, waddress2}, 16'hFEFF);
        tick();
        rst_n    = 1'b1;
        rd_ready = 1'b1;
        tick();

        // Idle parking.
        for (int i = 0; i < 10; i++) begin
            chk("idle_park1", waddress1, 8'hFE);
            chk("idle_park2", waddress2, 8'hFF);
            tick();
        end

        // Single pass, no stalls.
        t0 = tog_cnt;
        run_job(3, 1);
        chk("sp_ra0", {raddress1, raddress2}, 16'h0001);
        tick();
        chk("sp_ra1", {raddress1, raddress2}, 16'h0203);
        tick();
        chk("sp_ra2", {raddress1, raddress2}, 16'h0405);
        wait_done(1);
        chk("sp_toggles", tog_cnt - t0, 1);
        chk("sp_bank", sram_read_register, 1'b1);

        // Unexpected result in IDLE.
        man_d1    = {4{32'hDEAD_BEEF}};
        man_d2    = {4{32'hCAFE_F00D}};
        man_valid = 1'b1;
        #1;
        chk("unexp_park", {waddress1, waddress2}, 16'hFEFF);
        tick();
        man_valid = 1'b0;
        chk("unexp_err", err, 1'b1);
        tick();
        tick();
        chk("unexp_err_hold", err, 1'b1);
        run_job(2, 1);
        chk("start_clears_err", err, 1'b0);
        chk("start_busy", busy, 1'b1);
        wait_done(2);
        chk("unexp_bank", sram_read_register, 1'b0);

        // Multi-pass.
        t0 = tog_cnt;
        run_job(2, 3);
        wait_done(3);
        chk("mp_toggles", tog_cnt - t0, 3);
        chk("mp_bank", sram_read_register, 1'b1);

        // Reset while stuck in DRAIN (no results returned).
        dp_en = 1'b0;
        for (int i = 0; i < 4; i++) rd_exp.push_back({8'(2 * i), 8'(2 * i + 1)});
        pulse_start(4, 2);
        repeat (8) tick();
        chk("drain_busy", busy, 1'b1);
        chk("drain_raddr", raddress1, 8'h00);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_bank", sram_read_register, 1'b0);
        chk("mid_rst_park", {waddress1, waddress2}, 16'hFEFF);
        chk("mid_rst_rd_valid", rd_valid, 1'b0);
        exp_bank = 1'b0;
        tick();
        rst_n = 1'b1;
        dp_en = 1'b1;
        tick();

        // Zero-length starts: done one cycle later, no bank toggle.
        t0 = tog_cnt;
        run_job(0, 3);
        chk("zl_done", done, 1'b1);
        chk("zl_busy", busy, 1'b0);
        tick();
        chk("zl_done_pulse", done, 1'b0);
        wait_done(4);
        run_job(5, 0);
        chk("zp_done", done, 1'b1);
        wait_done(5);
        chk("zl_toggles", tog_cnt - t0, 0);

        // Read stall mid-pass.
        run_job(4, 1);
        chk("st_ra0", {raddress1, raddress2}, 16'h0001);
        tick();
        rd_ready = 1'b0;
        chk("st_ra1", {raddress1, raddress2}, 16'h0203);
        tick();
        chk("st_hold", {raddress1, raddress2}, 16'h0203);
        tick();
        rd_ready = 1'b1;
        chk("st_resume", {raddress1, raddress2}, 16'h0203);
        wait_done(6);
        chk("st_bank", sram_read_register, 1'b1);

        repeat (3) tick();
        chk("end_rd_q", rd_exp.size(), 0);
        chk("end_wr_q", wr_exp.size(), 0);
        chk("end_done_q", done_exp.size(), 0);
        chk("end_err", err, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pingpong_seq.md
PINGPONG_SEQ -- requirements
Module: pingpong_seq

Interface
REQ-001 Params: DUMMY_ADDR1 = 8'hFE, parking write address, port 1; DUMMY_ADDR2 = 8'hFF, parking write address, port 2.
REQ-002 clk  in  1  single clock, all state on rising edge; reset is asynchronous and active-low.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 start  in  1  one-cycle pulse, begins a job when idle.
REQ-005 num_pairs  in  7  address pairs per pass, 0..127; sampled on accepted start.
REQ-006 num_passes  in  4  passes per job, 0..15; sampled on accepted start.
REQ-007 rd_ready  in  1  datapath can accept one read pair this cycle.
REQ-008 res_valid  in  1  datapath presents one result pair.
REQ-009 res_data1, res_data2  in  128 each  result words for port 1 and port 2.
REQ-010 raddress1, raddress2  out  8 each  read addresses.
REQ-011 waddress1, waddress2  out  8 each  write addresses.
REQ-012 wdata1, wdata2  out  128 each  write data.
REQ-013 sram_read_register  out  1  bank select; 0 = read bank 0 / write bank 1, 1 = the reverse.
REQ-014 rd_valid  out  1  rdata from the memory interface is valid this cycle.
REQ-015 busy  out  1  a job is active.
REQ-016 done  out  1  one-cycle pulse at job end.
REQ-017 err  out  1  sticky unexpected-result flag.

Function
REQ-018 States: IDLE, READ, DRAIN, SWAP; encode as a package enum.
REQ-019 In IDLE, start with num_pairs != 0 and num_passes != 0 latches both counts, clears rd_ptr, wr_ptr and pass_cnt, and enters READ.
REQ-020 In IDLE, start with num_pairs == 0 or num_passes == 0 pulses done on the next cycle; no READ entry and no bank toggle.
REQ-021 start outside IDLE is ignored.
REQ-022 READ: raddress1 = {rd_ptr,0} and raddress2 = {rd_ptr,1}.
REQ-023 READ: rd_ptr increments on each cycle with rd_ready = 1.
REQ-024 When the last pair issues, the FSM moves to DRAIN.
REQ-025 rd_valid asserts exactly one cycle after each issuing cycle, matching the one-cycle SRAM read latency.
REQ-026 The memory interface writes the write bank every cycle, so with no accepted result waddress1/waddress2 hold DUMMY_ADDR1/DUMMY_ADDR2.
REQ-027 Data addresses never exceed 8'hFD.
REQ-028 Accepted result: res_valid = 1 in READ or DRAIN with wr_ptr < num_pairs.
REQ-029 On an accepted result: waddress1 = {wr_ptr,0}, waddress2 = {wr_ptr,1}, wdata = res_data (combinational, same cycle), and wr_ptr increments.
REQ-030 res_valid in any other case is dropped, parks the write addresses, and sets err.
REQ-031 err holds until reset or the next accepted start.
REQ-032 Reads and writes proceed concurrently in the same cycle.
REQ-033 The FSM enters SWAP the cycle after wr_ptr reaches num_pairs.
REQ-034 SWAP lasts one cycle: toggle sram_read_register, increment pass_cnt, clear rd_ptr and wr_ptr.
REQ-035 After SWAP, if pass_cnt == num_passes: pulse done and return to IDLE; else return to READ.
REQ-036 sram_read_register changes only in SWAP and is constant within a pass.
REQ-037 busy = 1 in READ, DRAIN and SWAP.
REQ-038 Idle outputs: raddress = 0, write addresses parked, rd_valid = 0.

Reset
REQ-039 Asserting rst_n low at any time forces IDLE, all counters = 0, sram_read_register = 0, rd_valid = 0, done = 0, err = 0 and busy = 0.
REQ-040 Write addresses park immediately on reset.
REQ-041 A job interrupted by reset is abandoned; bank contents are not guaranteed.

Structure
REQ-042 Shared package pingpong_pkg holds: the state enum, DUMMY_ADDR1/DUMMY_ADDR2, ADDR_W = 8, DATA_W = 128.
REQ-043 The pass counter and bank toggle form the natural sub-module pingpong_bank_sel.
REQ-044 Outputs connect one-to-one to the memory-interface ports of the same names.

Verification
REQ-045 Single pass, no stalls: start, num_pairs = 3, num_passes = 1 -> raddress pairs (0,1),(2,3),(4,5) on 3 consecutive cycles; rd_valid lags by 1; sram_read_register goes 0->1 once; done pulses once.
REQ-046 Idle parking: no result activity for 10 cycles -> waddress1 = 8'hFE and waddress2 = 8'hFF every cycle.
REQ-047 Read stall: rd_ready = 0 for 2 cycles mid-pass -> rd_ptr holds, no rd_valid gap mis-alignment, pass completes.
REQ-048 Multi-pass: num_passes = 3 -> bank select toggles 3 times, ending at 1; done pulses after the third SWAP.
REQ-049 Unexpected result: res_valid while in IDLE -> err = 1, no write to a data address; next start clears err.
REQ-050 Reset mid-DRAIN: rst_n low -> immediate IDLE and sram_read_register = 0; zero-length start (num_pairs = 0) -> done one cycle later, no toggle.
